hyperbus_cfg_regs: RTL

HYPERBUS_CFG_REGS -- requirements
Module: hyperbus_cfg_regs

---
 rtl/hyperbus_cfg_regs.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/hyperbus_cfg_regs.sv
// HyperBus controller configuration register file.
// Bus accesses hit staged copies; a guarded commit copies them to the active outputs.
module hyperbus_cfg_regs #(
  parameter int unsigned NR_CS     = 2,
  parameter int unsigned CS_SIZE   = 32'h400000,
  parameter int unsigned RST_T_ACC = 6,
  parameter int unsigned RST_T_ADD = 6,
  parameter int unsigned RST_T_CSM = 665,
  parameter int unsigned RST_T_RWR = 6,
  parameter int unsigned RST_T_DLY = 2000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  reg_valid_i,
  input  logic                  reg_write_i,
  input  logic [7:0]            reg_addr_i,
  input  logic [31:0]           reg_wdata_i,
  input  logic [3:0]            reg_wstrb_i,
  output logic [31:0]           reg_rdata_o,
  output logic                  reg_ready_o,
  output logic                  reg_error_o,
  input  logic                  phy_idle_i,
  output logic [31:0]           cfg_t_latency_access_o,
  output logic [31:0]           cfg_t_latency_additional_o,
  output logic [31:0]           cfg_t_cs_max_o,
  output logic [31:0]           cfg_t_read_write_recovery_o,
  output logic [31:0]           cfg_t_rwds_delay_line_o,
  output logic [64*NR_CS-1:0]   cfg_addr_mapping_o,
  output logic                  cfg_update_o
);

  localparam int unsigned NrTim = 5;
  localparam logic [31:0] RstTim [NrTim] = '{
    32'(RST_T_ACC), 32'(RST_T_ADD), 32'(RST_T_CSM), 32'(RST_T_RWR), 32'(RST_T_DLY)
  };

  typedef enum logic [0:0] {StIdle, StResp} state_e;
  state_e state_q, state_d;

  logic [31:0] tim_q       [NrTim];
  logic [31:0] tim_d       [NrTim];
  logic [31:0] act_tim_q   [NrTim];
  logic [31:0] start_q     [NR_CS];
  logic [31:0] start_d     [NR_CS];
  logic [31:0] end_q       [NR_CS];
  logic [31:0] end_d       [NR_CS];
  logic [31:0] act_start_q [NR_CS];
  logic [31:0] act_end_q   [NR_CS];

  logic        lock_q, lock_d;
  logic        pend_q, pend_d;
  logic        map_err_q, map_err_d;
  logic        update_q;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        pend_set, map_err_clr, commit, map_ok;

  logic        access, wr;
  logic [5:0]  widx;
  logic [31:0] cs_idx;
  logic        unused_addr;

  assign widx        = reg_addr_i[7:2];
  assign unused_addr = ^reg_addr_i[1:0];
  assign access      = (state_q == StIdle) && reg_valid_i;
  assign wr          = access && reg_write_i;
  // START_i/END_i live at word 8+2i / 9+2i.
  assign cs_idx      = 32'(widx[5:1]) - 32'd4;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    tim_d       = tim_q;
    start_d     = start_q;
    end_d       = end_q;
    lock_d      = lock_q;
    pend_set    = 1'b0;
    map_err_clr = 1'b0;
    rdata_d     = rdata_q;
    error_d     = error_q;
    if (access) begin
      rdata_d = '0;
      error_d = 1'b1;
      for (int k = 0; k < NrTim; k++) begin
        if (widx == 6'(k)) begin
          error_d = wr && lock_q;
          if (!reg_write_i) rdata_d = tim_q[k];
          else if (!lock_q) tim_d[k] = merge_bytes(tim_q[k], reg_wdata_i, reg_wstrb_i);
        end
      end
      if (widx == 6'd5) begin
        error_d = 1'b0;
        if (!reg_write_i) begin
          rdata_d = {30'd0, pend_q, lock_q};
        end else if (reg_wstrb_i[0]) begin
          if (reg_wdata_i[1] && lock_q) begin
            error_d = 1'b1;
          end else begin
            lock_d   = lock_q | reg_wdata_i[0];
            pend_set = reg_wdata_i[1];
          end
        end
      end
      if (widx == 6'd6) begin
        error_d = 1'b0;
        if (!reg_write_i) rdata_d = {29'd0, lock_q, pend_q, map_err_q};
        else map_err_clr = reg_wstrb_i[0] & reg_wdata_i[0];
      end
      if (widx >= 6'd8) begin
        for (int i = 0; i < NR_CS; i++) begin
          if (cs_idx == 32'(i)) begin
            error_d = wr && lock_q;
            if (!reg_write_i) begin
              rdata_d = widx[0] ? end_q[i] : start_q[i];
            end else if (!lock_q) begin
              if (widx[0]) end_d[i] = merge_bytes(end_q[i], reg_wdata_i, reg_wstrb_i);
              else start_d[i] = merge_bytes(start_q[i], reg_wdata_i, reg_wstrb_i);
            end
          end
        end
      end
    end
  end

  // The map check sees same-cycle bus writes so the commit copies post-write values.
  always_comb begin
    map_ok = 1'b1;
    for (int i = 0; i < NR_CS; i++) begin
      if (start_d[i] > end_d[i]) map_ok = 1'b0;
    end
    commit    = pend_q && phy_idle_i;
    pend_d    = commit ? 1'b0 : (pend_q | pend_set);
    map_err_d = (commit && !map_ok) | (map_err_q & ~map_err_clr);
    state_d   = state_q;
    unique case (state_q)
      StIdle:  if (reg_valid_i) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      lock_q    <= 1'b0;
      pend_q    <= 1'b0;
      map_err_q <= 1'b0;
      update_q  <= 1'b0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      for (int k = 0; k < NrTim; k++) begin
        tim_q[k]     <= RstTim[k];
        act_tim_q[k] <= RstTim[k];
      end
      for (int i = 0; i < NR_CS; i++) begin
        start_q[i]     <= CS_SIZE * 32'(i);
        end_q[i]       <= CS_SIZE * 32'(i + 1) - 32'd1;
        act_start_q[i] <= CS_SIZE * 32'(i);
        act_end_q[i]   <= CS_SIZE * 32'(i + 1) - 32'd1;
      end
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      pend_q    <= pend_d;
      map_err_q <= map_err_d;
      update_q  <= commit && map_ok;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      tim_q     <= tim_d;
      start_q   <= start_d;
      end_q     <= end_d;
      if (commit && map_ok) begin
        act_tim_q   <= tim_d;
        act_start_q <= start_d;
        act_end_q   <= end_d;
      end
    end
  end

  assign reg_ready_o                 = (state_q == StResp);
  assign reg_rdata_o                 = rdata_q;
  assign reg_error_o                 = error_q;
  assign cfg_update_o                = update_q;
  assign cfg_t_latency_access_o      = act_tim_q[0];
  assign cfg_t_latency_additional_o  = act_tim_q[1];
  assign cfg_t_cs_max_o              = act_tim_q[2];
  assign cfg_t_read_write_recovery_o = act_tim_q[3];
  assign cfg_t_rwds_delay_line_o     = act_tim_q[4];

  for (genvar i = 0; i < NR_CS; i++) begin : g_map
    assign cfg_addr_mapping_o[64*i +: 32]      = act_start_q[i];
    assign cfg_addr_mapping_o[64*i + 32 +: 32] = act_end_q[i];
  end

endmodule
